controlador_botoes: RTL and testbench



---
 rtl/botoes_pkg.sv | 18 +
 rtl/botao_canal.sv | 165 ++++++++++++++++
 rtl/controlador_botoes.sv | 41 ++++
 tb/tb_controlador_botoes.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/botoes_pkg.sv
// Shared definitions for the pushbutton controller: per-channel FSM encoding
// and the counter sizing helper.
`timescale 1ns/1ps
package botoes_pkg;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSIONADO = 2'd2,
        DEB_SOLTA   = 2'd3
    } estado_e;

    // One extra bit so the counter can hold the parameter value itself.
    function automatic int largura_cnt(input int valor);
        return $clog2(valor) + 1;
    endfunction

endpackage

// File: rtl/botao_canal.sv
// One button channel: two-flop synchroniser, press/release debouncer,
// hold timer with long-press and auto-repeat pulses. All outputs registered.
`timescale 1ns/1ps
module botao_canal
    import botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int LONGO_CICLOS    = 1024,
    parameter int REPETE_CICLOS   = 256,
    parameter int ATIVO_BAIXO     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic b_in_i,
    output logic pulso_o,
    output logic solto_o,
    output logic hold_o,
    output logic longo_o,
    output logic repete_o
);

    localparam int W_DEB   = largura_cnt(DEBOUNCE_CICLOS);
    localparam int W_LONGO = largura_cnt(LONGO_CICLOS);
    localparam int W_REP   = largura_cnt(REPETE_CICLOS);

    localparam logic               NIVEL_SOLTO = (ATIVO_BAIXO != 0) ? 1'b1 : 1'b0;
    localparam logic [W_DEB-1:0]   DEB_ULT     = W_DEB'(DEBOUNCE_CICLOS - 1);
    localparam logic [W_LONGO-1:0] LONGO_MAX   = W_LONGO'(LONGO_CICLOS);
    localparam logic [W_LONGO-1:0] LONGO_ULT   = W_LONGO'(LONGO_CICLOS - 1);
    localparam logic [W_LONGO-1:0] LONGO_PEN   = W_LONGO'(LONGO_CICLOS - 2);
    localparam logic [W_REP-1:0]   REP_ULT     = W_REP'(REPETE_CICLOS - 1);
    localparam bit                 REP_ATIVO   = (REPETE_CICLOS > 0);

    logic [1:0]         sync_q;
    estado_e            estado_q, estado_d;
    logic [W_DEB-1:0]   deb_q, deb_d;
    logic [W_LONGO-1:0] hold_q, hold_d;
    logic [W_REP-1:0]   rep_q, rep_d;
    logic               pulso_q, pulso_d;
    logic               solto_q, solto_d;
    logic               hold_out_q, hold_out_d;
    logic               longo_q, longo_d;
    logic               repete_q, repete_d;
    logic               pressionado;

    assign pressionado = sync_q[1] ^ NIVEL_SOLTO;

    // Synchroniser, FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= {2{NIVEL_SOLTO}};
            estado_q   <= OCIOSO;
            deb_q      <= '0;
            hold_q     <= '0;
            rep_q      <= '0;
            pulso_q    <= 1'b0;
            solto_q    <= 1'b0;
            hold_out_q <= 1'b0;
            longo_q    <= 1'b0;
            repete_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], b_in_i};
            estado_q   <= estado_d;
            deb_q      <= deb_d;
            hold_q     <= hold_d;
            rep_q      <= rep_d;
            pulso_q    <= pulso_d;
            solto_q    <= solto_d;
            hold_out_q <= hold_out_d;
            longo_q    <= longo_d;
            repete_q   <= repete_d;
        end
    end

    // Next-state logic and pulse generation for the channel FSM.
    always_comb begin
        estado_d = estado_q;
        deb_d    = deb_q;
        hold_d   = hold_q;
        rep_d    = rep_q;
        pulso_d  = 1'b0;
        solto_d  = 1'b0;
        longo_d  = 1'b0;
        repete_d = 1'b0;
        case (estado_q)
            OCIOSO: begin
                hold_d = '0;
                rep_d  = '0;
                if (pressionado) begin
                    estado_d = DEB_PRESS;
                    deb_d    = W_DEB'(1);
                end else begin
                    deb_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!pressionado) begin
                    estado_d = OCIOSO;
                    deb_d    = '0;
                end else if (deb_q == DEB_ULT) begin
                    estado_d = PRESSIONADO;
                    pulso_d  = 1'b1;
                    deb_d    = '0;
                    hold_d   = '0;
                    rep_d    = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            PRESSIONADO: begin
                if (!pressionado) begin
                    estado_d = DEB_SOLTA;
                    deb_d    = W_DEB'(1);
                end else begin
                    deb_d = '0;
                end
                // The hold timer runs on every pressed cycle, including the one that starts a release.
                if (hold_q < LONGO_MAX) begin
                    hold_d  = hold_q + 1'b1;
                    longo_d = (hold_q == LONGO_PEN);
                end else begin
                    hold_d = hold_q;
                end
                if (REP_ATIVO && (hold_q >= LONGO_ULT)) begin
                    if (rep_q == REP_ULT) begin
                        repete_d = 1'b1;
                        rep_d    = '0;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end else begin
                    rep_d = rep_q;
                end
            end
            DEB_SOLTA: begin
                if (pressionado) begin
                    estado_d = PRESSIONADO;
                    deb_d    = '0;
                end else if (deb_q == DEB_ULT) begin
                    estado_d = OCIOSO;
                    solto_d  = 1'b1;
                    deb_d    = '0;
                    hold_d   = '0;
                    rep_d    = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                estado_d = OCIOSO;
                deb_d    = '0;
                hold_d   = '0;
                rep_d    = '0;
            end
        endcase
        hold_out_d = (estado_d == PRESSIONADO) || (estado_d == DEB_SOLTA);
    end

    assign pulso_o  = pulso_q;
    assign solto_o  = solto_q;
    assign hold_o   = hold_out_q;
    assign longo_o  = longo_q;
    assign repete_o = repete_q;

endmodule

// File: rtl/controlador_botoes.sv
// Multi-channel pushbutton controller: one independent botao_canal per button,
// outputs gathered into per-function buses.
`timescale 1ns/1ps
module controlador_botoes
    import botoes_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int LONGO_CICLOS    = 1024,
    parameter int REPETE_CICLOS   = 256,
    parameter int ATIVO_BAIXO     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_BOTOES-1:0] b_in,
    output logic [N_BOTOES-1:0] b_pulso,
    output logic [N_BOTOES-1:0] b_solto,
    output logic [N_BOTOES-1:0] b_hold_out,
    output logic [N_BOTOES-1:0] b_longo,
    output logic [N_BOTOES-1:0] b_repete
);

    for (genvar g = 0; g < N_BOTOES; g++) begin : g_canal
        botao_canal #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
            .LONGO_CICLOS   (LONGO_CICLOS),
            .REPETE_CICLOS  (REPETE_CICLOS),
            .ATIVO_BAIXO    (ATIVO_BAIXO)
        ) u_canal (
            .clk     (clk),
            .rst_n   (rst_n),
            .b_in_i  (b_in[g]),
            .pulso_o (b_pulso[g]),
            .solto_o (b_solto[g]),
            .hold_o  (b_hold_out[g]),
            .longo_o (b_longo[g]),
            .repete_o(b_repete[g])
        );
    end

endmodule

// File: tb/tb_controlador_botoes.sv
// Bench for controlador_botoes: a run-length button model checked every cycle,
// plus directed scenarios with hand-computed cycle expectations.
`timescale 1ns/1ps
module tb_controlador_botoes;

    localparam int N     = 2;
    localparam int DEB   = 4;
    localparam int LONGO = 20;
    localparam int REP   = 5;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] b_in  = '1;
    logic [N-1:0] b_pulso, b_solto, b_hold_out, b_longo, b_repete;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model state: synchroniser copy, confirmed level, run length, pressed time.
    logic [N-1:0] m_sy1 = '1, m_sy2 = '1, m_lvl = '0;
    int           m_run [N];
    int           m_t   [N];
    logic [N-1:0] e_pul = '0, e_sol = '0, e_hold = '0, e_lon = '0, e_rep = '0;

    controlador_botoes #(
        .N_BOTOES       (N),
        .DEBOUNCE_CICLOS(DEB),
        .LONGO_CICLOS   (LONGO),
        .REPETE_CICLOS  (REP),
        .ATIVO_BAIXO    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b_in      (b_in),
        .b_pulso   (b_pulso),
        .b_solto   (b_solto),
        .b_hold_out(b_hold_out),
        .b_longo   (b_longo),
        .b_repete  (b_repete)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_v(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // A press or release is accepted once the synchronised level has disagreed
    // with the confirmed level for DEB consecutive cycles; long/repeat follow
    // from the count of pressed cycles since confirmation.
    initial begin : modelo
        logic pr;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0;
            m_t[i]   = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    m_sy1[i] = 1'b1; m_sy2[i] = 1'b1; m_lvl[i] = 1'b0;
                    m_run[i] = 0; m_t[i] = 0;
                    e_pul[i] = 1'b0; e_sol[i] = 1'b0; e_hold[i] = 1'b0;
                    e_lon[i] = 1'b0; e_rep[i] = 1'b0;
                end else begin
                    pr = ~m_sy2[i];
                    e_pul[i] = 1'b0; e_sol[i] = 1'b0; e_lon[i] = 1'b0; e_rep[i] = 1'b0;
                    if (m_lvl[i] && m_run[i] == 0) begin
                        m_t[i]++;
                        e_lon[i] = (m_t[i] == LONGO - 1);
                        e_rep[i] = (REP > 0) && (m_t[i] > LONGO - 1) && (((m_t[i] - (LONGO - 1)) % REP) == 0);
                    end
                    if (pr != m_lvl[i]) m_run[i]++;
                    else m_run[i] = 0;
                    if (m_run[i] == DEB) begin
                        m_run[i] = 0;
                        m_t[i]   = 0;
                        m_lvl[i] = ~m_lvl[i];
                        if (m_lvl[i]) e_pul[i] = 1'b1;
                        else e_sol[i] = 1'b1;
                    end
                    e_hold[i] = m_lvl[i];
                    m_sy2[i] = m_sy1[i];
                    m_sy1[i] = b_in[i];
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin : comparador
        forever begin
            @(posedge clk);
            #2;
            check_v("model_pulso", b_pulso, e_pul);
            check_v("model_solto", b_solto, e_sol);
            check_v("model_hold", b_hold_out, e_hold);
            check_v("model_longo", b_longo, e_lon);
            check_v("model_repete", b_repete, e_rep);
        end
    end

    initial begin : estimulo
        int k;
        int cnt;
        int at;

        rst_n = 1'b0;
        b_in  = '1;
        repeat (3) tick;
        check_v("reset_pulso", b_pulso, 2'b00);
        check_v("reset_hold", b_hold_out, 2'b00);
        check_v("reset_solto", b_solto, 2'b00);
        rst_n = 1'b1;
        tick;

        // Clean press on channel 0.
        b_in[0] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick;
            check_v("press_pulso", b_pulso, (n == 6) ? 2'b01 : 2'b00);
            check_v("press_hold", b_hold_out, (n >= 6) ? 2'b01 : 2'b00);
        end

        // Two-cycle release glitch while held.
        for (int n = 0; n < 14; n++) begin
            b_in[0] = (n < 2) ? 1'b1 : 1'b0;
            tick;
            check_v("glitch_solto", b_solto, 2'b00);
            check_v("glitch_pulso", b_pulso, 2'b00);
            check_v("glitch_hold", b_hold_out, 2'b01);
        end

        // Clean release.
        b_in[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick;
            check_v("release_solto", b_solto, (n == 6) ? 2'b01 : 2'b00);
            check_v("release_hold", b_hold_out, (n < 6) ? 2'b01 : 2'b00);
        end
        repeat (4) tick;

        // Long hold: longo 19 after pulso, repeats every 5, release at +40.
        b_in[0] = 1'b0;
        for (int n = 1; n <= 56; n++) begin
            tick;
            check_v("long_longo", b_longo, (n == 25) ? 2'b01 : 2'b00);
            check_v("long_repete", b_repete, (n >= 30 && n <= 45 && (n % 5) == 0) ? 2'b01 : 2'b00);
            check_v("long_solto", b_solto, (n == 52) ? 2'b01 : 2'b00);
            check_v("long_hold", b_hold_out, (n >= 6 && n < 52) ? 2'b01 : 2'b00);
            if (n == 46) b_in[0] = 1'b1;
        end
        repeat (4) tick;

        // Bounce for 20 cycles, then stable pressed.
        k = cyc; cnt = 0; at = -1;
        for (int n = 0; n < 32; n++) begin
            b_in[0] = (n >= 20) ? 1'b0 : ((((n / 2) % 2) == 0) ? 1'b0 : 1'b1);
            tick;
            if (b_pulso[0]) begin
                cnt++;
                at = cyc - k;
            end
        end
        check_i("bounce_count", cnt, 1);
        check_i("bounce_cycle", at, 26);
        b_in[0] = 1'b1;
        repeat (10) tick;

        // Two channels pressed one cycle apart.
        b_in[0] = 1'b0;
        tick;
        check_v("two_pulso", b_pulso, 2'b00);
        b_in[1] = 1'b0;
        for (int n = 2; n <= 9; n++) begin
            tick;
            check_v("two_pulso", b_pulso, (n == 6) ? 2'b01 : ((n == 7) ? 2'b10 : 2'b00));
        end

        // Reset in the middle of a hold.
        repeat (5) tick;
        check_v("prereset_hold", b_hold_out, 2'b11);
        #3;
        rst_n = 1'b0;
        #1;
        check_v("midreset_hold", b_hold_out, 2'b00);
        check_v("midreset_pulso", b_pulso, 2'b00);
        check_v("midreset_solto", b_solto, 2'b00);
        repeat (2) tick;
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick;
            check_v("after_reset_pulso", b_pulso, (n == 6) ? 2'b11 : 2'b00);
            check_v("after_reset_solto", b_solto, 2'b00);
        end

        b_in = '1;
        repeat (10) tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
